// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, 64-bit sequencer state type and
// an opcode-support helper. Used by the ALU, the sequencer and the decoder.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } seq_state_t;

  function automatic logic op_supported(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu64_sequencer_if.sv
// Bus bundle between the 64-bit sequencer and its execute stage.
//   req_*  : request handshake and 64-bit operands/opcode (into the sequencer)
//   rsp_*  : response handshake, 64-bit result and flags (out of the sequencer)
//   alu_*  : word-wide drive to the 32-bit ALU and its combinational result
// The slave modport is the sequencer view; master is the execute stage that
// issues requests, consumes responses and hosts the ALU.
interface alu64_sequencer_if #(
  parameter int unsigned HALF_W = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [2*HALF_W-1:0]   req_a;
  logic [2*HALF_W-1:0]   req_b;
  logic [2:0]            req_op;

  logic [HALF_W-1:0]     alu_a;
  logic [HALF_W-1:0]     alu_b;
  logic [2:0]            alu_op;
  logic                  alu_cin;
  logic [HALF_W-1:0]     alu_result;
  logic                  alu_cout;
  logic                  alu_zero;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*HALF_W-1:0]   rsp_result;
  logic                  rsp_cout;
  logic                  rsp_zero;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_cout, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_err,
           alu_a, alu_b, alu_op, alu_cin
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_cout, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_err,
           alu_a, alu_b, alu_op, alu_cin
  );

endinterface

// File: rtl/alu64_sequencer.sv
// Two-pass 64-bit execute sequencer in front of a 32-bit combinational ALU.
// Runs the low word then the high word through the ALU, chaining carry, and
// returns a registered 64-bit result with carry/zero/error flags.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave view of alu64_sequencer_if (req/rsp handshakes + ALU drive)
module alu64_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned HALF_W = 32
) (
  input logic             clk,
  input logic             rst,
  alu64_sequencer_if.slave bus
);

  localparam int unsigned FULL_W = 2 * HALF_W;

  seq_state_t        r_state, w_state_next;
  logic [FULL_W-1:0] r_a, w_a;
  logic [FULL_W-1:0] r_b, w_b;
  logic [2:0]        r_op, w_op;
  logic [HALF_W-1:0] r_lo_res, w_lo_res;
  logic              r_lo_c, w_lo_c;
  logic [FULL_W-1:0] r_rsp_result, w_rsp_result;
  logic              r_rsp_cout, w_rsp_cout;
  logic              r_rsp_zero, w_rsp_zero;
  logic              r_rsp_err, w_rsp_err;

  logic [HALF_W-1:0] w_alu_a, w_alu_b;
  logic [2:0]        w_alu_op;
  logic              w_alu_cin;
  logic              w_is_sub;
  logic              w_is_arith;
  logic              w_ovf;
  logic              w_unused;

  // The ALU zero flag only describes one word, so the 64-bit zero is rebuilt.
  assign w_unused = bus.alu_zero;

  assign w_is_sub   = (r_op == ALU_SUB) || (r_op == ALU_SLT);
  assign w_is_arith = w_is_sub || (r_op == ALU_ADD);

  // Signed overflow of a - b: operand signs differ and the result sign differs from a.
  assign w_ovf = (r_a[FULL_W-1] != r_b[FULL_W-1]) &&
                 (bus.alu_result[HALF_W-1] != r_a[FULL_W-1]);

  always_comb begin
    w_state_next = r_state;
    w_a          = r_a;
    w_b          = r_b;
    w_op         = r_op;
    w_lo_res     = r_lo_res;
    w_lo_c       = r_lo_c;
    w_rsp_result = r_rsp_result;
    w_rsp_cout   = r_rsp_cout;
    w_rsp_zero   = r_rsp_zero;
    w_rsp_err    = r_rsp_err;
    w_alu_a      = '0;
    w_alu_b      = '0;
    w_alu_op     = '0;
    w_alu_cin    = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_a  = bus.req_a;
          w_b  = bus.req_b;
          w_op = bus.req_op;
          if (op_supported(bus.req_op)) begin
            w_rsp_err    = 1'b0;
            w_state_next = LO;
          end else begin
            // Unsupported opcodes bypass the ALU and answer with an error.
            w_rsp_result = '0;
            w_rsp_cout   = 1'b0;
            w_rsp_zero   = 1'b1;
            w_rsp_err    = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      LO: begin
        w_alu_a      = r_a[HALF_W-1:0];
        w_alu_b      = r_b[HALF_W-1:0];
        w_alu_op     = (r_op == ALU_SLT) ? ALU_SUB : r_op;
        w_alu_cin    = w_is_sub;
        w_lo_res     = bus.alu_result;
        w_lo_c       = bus.alu_cout;
        w_state_next = HI;
      end
      HI: begin
        w_alu_a   = r_a[FULL_W-1:HALF_W];
        w_alu_b   = r_b[FULL_W-1:HALF_W];
        w_alu_op  = (r_op == ALU_SLT) ? ALU_SUB : r_op;
        w_alu_cin = w_is_arith & r_lo_c;
        w_rsp_err = 1'b0;
        if (r_op == ALU_SLT) begin
          w_rsp_result = {{(FULL_W-1){1'b0}}, bus.alu_result[HALF_W-1] ^ w_ovf};
          w_rsp_cout   = 1'b0;
        end else begin
          w_rsp_result = {bus.alu_result, r_lo_res};
          w_rsp_cout   = w_is_arith & bus.alu_cout;
        end
        w_rsp_zero   = (w_rsp_result == '0);
        w_state_next = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_lo_res     <= '0;
      r_lo_c       <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_a          <= w_a;
      r_b          <= w_b;
      r_op         <= w_op;
      r_lo_res     <= w_lo_res;
      r_lo_c       <= w_lo_c;
      r_rsp_result <= w_rsp_result;
      r_rsp_cout   <= w_rsp_cout;
      r_rsp_zero   <= w_rsp_zero;
      r_rsp_err    <= w_rsp_err;
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.rsp_valid  = (r_state == DONE);
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_cout   = r_rsp_cout;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.alu_a      = w_alu_a;
  assign bus.alu_b      = w_alu_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.alu_cin    = w_alu_cin;

endmodule

// File: tb/tb_alu64_sequencer.sv
// Self-checking bench for alu64_sequencer. Hosts a behavioural 32-bit ALU,
// pushes expected responses to a scoreboard queue when a request is driven and
// pops/compares them when the response appears.
module tb_alu64_sequencer;

  typedef struct packed {
    logic [63:0] result;
    logic        cout;
    logic        zero;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  rsp_t sb[$];

  alu64_sequencer_if #(.HALF_W(32)) bus ();

  alu64_sequencer #(.HALF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU32Bit: op 110 computes a + ~b + cin.
  logic [32:0] alu_sum;
  logic [31:0] alu_res;
  always_comb begin
    alu_sum = '0;
    alu_res = '0;
    case (bus.alu_op)
      3'b000: alu_res = bus.alu_a & bus.alu_b;
      3'b001: alu_res = bus.alu_a | bus.alu_b;
      3'b010: alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'b0, bus.alu_cin};
      3'b110: alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {32'b0, bus.alu_cin};
      default: alu_res = '0;
    endcase
    if (bus.alu_op == 3'b010 || bus.alu_op == 3'b110) alu_res = alu_sum[31:0];
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_cout   = alu_sum[32];
  assign bus.alu_zero   = (alu_res == 32'd0);

  function automatic rsp_t mk(input logic [63:0] res, input logic c, input logic e);
    rsp_t r;
    r.result = res;
    r.cout   = c;
    r.zero   = (res == 64'd0);
    r.err    = e;
    return r;
  endfunction

  function automatic rsp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] op);
    rsp_t        r;
    logic [64:0] s;
    r = '0;
    s = '0;
    case (op)
      3'b000: r.result = a & b;
      3'b001: r.result = a | b;
      3'b010: begin s = {1'b0, a} + {1'b0, b}; r.result = s[63:0]; r.cout = s[64]; end
      3'b110: begin s = {1'b0, a} + {1'b0, ~b} + 65'd1; r.result = s[63:0]; r.cout = s[64]; end
      3'b111: r.result = {63'b0, ($signed(a) < $signed(b))};
      default: r.err = 1'b1;
    endcase
    r.zero = (r.result == 64'd0);
    return r;
  endfunction

  // Drives one request, waits for acceptance then for rsp_valid (bounded).
  // lat counts edges from the acceptance edge (inclusive) to rsp_valid.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        output int lat, output int acc);
    int n;
    @(negedge clk);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout op=%b: rsp_valid=%b after %0d edges, want 1", op, bus.rsp_valid, lat);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_cout, bus.rsp_zero,
         bus.rsp_err} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h c=%b z=%b e=%b, want 1 0 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_cout, bus.rsp_zero,
               bus.rsp_err);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin} !== 68'd0) begin
      errors++;
      $display("FAIL reset_alu_drive: got a=%h b=%h op=%b cin=%b, want all 0",
               bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin);
    end
  endtask

  // Table-driven arithmetic/logic cases with explicit expected values and latency.
  task automatic run_table(input string name, input logic [63:0] ta[], input logic [63:0] tb_[],
                           input logic [2:0] top[], input logic [63:0] tres[], input logic tc[]);
    int   lat, acc;
    rsp_t exp, got;
    for (int i = 0; i < ta.size(); i++) begin
      sb.push_back(mk(tres[i], tc[i], 1'b0));
      run_op(ta[i], tb_[i], top[i], lat, acc);
      exp = sb.pop_front();
      got = {bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s[%0d]: got res=%h c=%b z=%b e=%b, want res=%h c=%b z=%b e=%b", name, i,
                 got.result, got.cout, got.zero, got.err, exp.result, exp.cout, exp.zero, exp.err);
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL %s_latency[%0d]: got %0d edges, want 3", name, i, lat);
      end
      consume();
    end
  endtask

  task automatic test_add();
    run_table("add", '{64'h00000000_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF},
              '{64'h1, 64'hFFFFFFFF_FFFFFFFF}, '{3'b010, 3'b010},
              '{64'h00000001_00000000, 64'hFFFFFFFF_FFFFFFFE}, '{1'b0, 1'b1});
  endtask

  task automatic test_sub();
    run_table("sub", '{64'h00000001_00000000, 64'h5}, '{64'h1, 64'h5}, '{3'b110, 3'b110},
              '{64'h00000000_FFFFFFFF, 64'h0}, '{1'b1, 1'b1});
  endtask

  task automatic test_slt();
    run_table("slt", '{64'hFFFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000},
              '{64'h1, 64'hFFFFFFFF_FFFFFFFF, 64'h1}, '{3'b111, 3'b111, 3'b111},
              '{64'h1, 64'h0, 64'h1}, '{1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_backpressure();
    int   lat, acc;
    rsp_t exp, got;
    sb.push_back(mk(64'h0F0F0F0F_0F0F0F0F, 1'b0, 1'b0));
    run_op(64'hFFFFFFFF_FFFFFFFF, 64'h0F0F0F0F_0F0F0F0F, 3'b000, lat, acc);
    exp = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = {bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_err};
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || got !== exp) begin
        errors++;
        $display("FAIL stall[%0d]: got vld=%b rdy=%b res=%h c=%b z=%b, want vld=1 rdy=0 res=%h c=%b z=%b",
                 i, bus.rsp_valid, bus.req_ready, got.result, got.cout, got.zero,
                 exp.result, exp.cout, exp.zero);
      end
    end
    consume();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: got vld=%b rdy=%b, want vld=0 rdy=1", bus.rsp_valid, bus.req_ready);
    end
    sb.push_back(mk(64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0));
    run_op(64'hAAAAAAAA_AAAAAAAA, 64'h55555555_55555555, 3'b001, lat, acc);
    exp = sb.pop_front();
    got = {bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL or: got res=%h c=%b z=%b e=%b, want res=%h c=%b z=%b e=%b",
               got.result, got.cout, got.zero, got.err, exp.result, exp.cout, exp.zero, exp.err);
    end
    consume();
  endtask

  task automatic test_reset_mid_op();
    int   lat, acc;
    int   seen;
    rsp_t exp, got;
    @(negedge clk);
    bus.req_a     = 64'h00000003_00000001;
    bus.req_b     = 64'h00000004_00000002;
    bus.req_op    = 3'b010;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.alu_a !== 32'h3 || bus.alu_b !== 32'h4) begin
      errors++;
      $display("FAIL hi_drive: got alu_a=%h alu_b=%h, want 3 4", bus.alu_a, bus.alu_b);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_cout, bus.rsp_zero,
         bus.rsp_err} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midop_reset_outputs: got rdy=%b vld=%b res=%h c=%b z=%b e=%b, want 1 0 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_cout, bus.rsp_zero,
               bus.rsp_err);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin} !== 68'd0) begin
      errors++;
      $display("FAIL midop_reset_alu: got a=%h b=%h op=%b cin=%b, want all 0",
               bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL discarded_op: rsp_valid high on %0d cycles, want 0", seen);
    end
    sb.push_back(mk(64'h00000007_00000003, 1'b0, 1'b0));
    run_op(64'h00000003_00000001, 64'h00000004_00000002, 3'b010, lat, acc);
    exp = sb.pop_front();
    got = {bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_err};
    checks++;
    if (got !== exp || lat != 3) begin
      errors++;
      $display("FAIL post_reset_add: got res=%h c=%b z=%b e=%b lat=%0d, want res=%h c=%b z=%b e=%b lat=3",
               got.result, got.cout, got.zero, got.err, lat, exp.result, exp.cout, exp.zero,
               exp.err);
    end
    consume();
  endtask

  task automatic test_bad_op();
    int         lat, acc;
    rsp_t       exp, got;
    logic [2:0] bad[3] = '{3'b100, 3'b011, 3'b101};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(64'd0, 1'b0, 1'b1));
      run_op(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, bad[i], lat, acc);
      exp = sb.pop_front();
      got = {bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bad_op[%b]: got res=%h c=%b z=%b e=%b, want res=%h c=%b z=%b e=%b",
                 bad[i], got.result, got.cout, got.zero, got.err, exp.result, exp.cout,
                 exp.zero, exp.err);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL bad_op_latency[%b]: got %0d edges, want 1", bad[i], lat);
      end
      consume();
    end
  endtask

  // rsp_ready held high: random supported ops, one accepted every 4 cycles.
  task automatic test_back_to_back();
    int          lat, acc, prev_acc;
    rsp_t        exp, got;
    logic [63:0] a, b;
    logic [2:0]  op;
    logic [2:0]  ops[5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    bus.rsp_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (i == 0) b = a;
      op = ops[$urandom_range(0, 4)];
      sb.push_back(model(a, b, op));
      run_op(a, b, op, lat, acc);
      exp = sb.pop_front();
      got = {bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b[%0d] op=%b a=%h b=%h: got res=%h c=%b z=%b e=%b, want res=%h c=%b z=%b e=%b",
                 i, op, a, b, got.result, got.cout, got.zero, got.err, exp.result, exp.cout,
                 exp.zero, exp.err);
      end
      if (i > 0) begin
        checks++;
        if (acc - prev_acc != 4) begin
          errors++;
          $display("FAIL b2b_throughput[%0d]: got %0d cycles between accepts, want 4", i,
                   acc - prev_acc);
        end
      end
      prev_acc = acc;
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_add();
    test_sub();
    test_slt();
    test_backpressure();
    test_reset_mid_op();
    test_bad_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
